// File: rtl/mod_sumrest_arbiter_if.sv
// Requester-side bus of the sum/rest arbiter.
// Both requesters share this bundle:
//   REQ0/REQ1, OP0/OP1, A0/B0, A1/B1 : request, opcode (0 sum, 1 rest) and operands
//   GNT0/GNT1                        : one-cycle accept pulse (combinational in IDLE)
//   SEL, RES, COUT                   : registered mux select, result, carry/borrow
//   DONE0/DONE1                      : one-cycle result-valid pulse to the winner
//   BUSY                             : high whenever the arbiter is not IDLE
// Modport slave is the arbiter side; modport master is the requester side.
interface mod_sumrest_arbiter_if #(
  parameter int unsigned W = 8
);
  logic         REQ0;
  logic         REQ1;
  logic         OP0;
  logic         OP1;
  logic [W-1:0] A0;
  logic [W-1:0] B0;
  logic [W-1:0] A1;
  logic [W-1:0] B1;
  logic         GNT0;
  logic         GNT1;
  logic         SEL;
  logic [W-1:0] RES;
  logic         COUT;
  logic         DONE0;
  logic         DONE1;
  logic         BUSY;

  modport slave (
    input  REQ0, REQ1, OP0, OP1, A0, B0, A1, B1,
    output GNT0, GNT1, SEL, RES, COUT, DONE0, DONE1, BUSY
  );

  modport master (
    output REQ0, REQ1, OP0, OP1, A0, B0, A1, B1,
    input  GNT0, GNT1, SEL, RES, COUT, DONE0, DONE1, BUSY
  );
endinterface

// File: rtl/mod_sumrest_arbiter.sv
// Two-requester round-robin arbiter in front of a shared W-bit add/subtract unit.
// Ports:
//   CLK   : clock, all state on the rising edge
//   RST_N : synchronous active-low reset
//   bus   : mod_sumrest_arbiter_if.slave (requests, operands, grants, results)
// Flow: IDLE (grant + latch operands) -> EXEC (compute) -> DONE (result pulse)
// -> IDLE, giving one operation every three cycles.
module mod_sumrest_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  mod_sumrest_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;   // 1: requester 1 was served last
  logic         win_q, win_d;     // latched winner id
  logic         op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         sel_q, sel_d;
  logic [W-1:0] res_q, res_d;
  logic         cout_q, cout_d;
  logic         done0_q, done0_d;
  logic         done1_q, done1_d;
  logic         busy_q, busy_d;

  logic         gnt0, gnt1;
  logic [W:0]   sum_w;
  logic [W:0]   diff_w;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    // One extra bit: MSB is the carry for the sum and the borrow (A<B) for
    // the rest, since |A-B| < 2^W.
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    diff_w = {1'b0, a_q} - {1'b0, b_q};

    case (state_q)
      S_IDLE: begin
        if (RST_N) begin
          // Requester 0 wins alone, or on a tie when requester 1 went last.
          if (bus.REQ0 && (!bus.REQ1 || last_q)) begin
            gnt0 = 1'b1;
          end else if (bus.REQ1) begin
            gnt1 = 1'b1;
          end
        end
        if (gnt0 || gnt1) begin
          win_d   = gnt1;
          last_d  = gnt1;
          op_d    = gnt1 ? bus.OP1 : bus.OP0;
          a_d     = gnt1 ? bus.A1  : bus.A0;
          b_d     = gnt1 ? bus.B1  : bus.B0;
          sel_d   = gnt1 ? bus.OP1 : bus.OP0;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = op_q ? diff_w[W-1:0] : sum_w[W-1:0];
        cout_d  = op_q ? diff_w[W]     : sum_w[W];
        done0_d = ~win_q;
        done1_d = win_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.GNT0  = gnt0;
  assign bus.GNT1  = gnt1;
  assign bus.SEL   = sel_q;
  assign bus.RES   = res_q;
  assign bus.COUT  = cout_q;
  assign bus.DONE0 = done0_q;
  assign bus.DONE1 = done1_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_mod_sumrest_arbiter.sv
// Randomized scoreboard bench for mod_sumrest_arbiter (W=8).
module tb_mod_sumrest_arbiter;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  mod_sumrest_arbiter_if #(.W(W)) bus ();

  mod_sumrest_arbiter #(.W(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int res;
    int cout;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;

  task automatic chk(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: an operation occupies the unit for the grant cycle plus
  // two more; ties go to whoever was not served last.
  int m_cnt   = 0;
  int m_last  = 1;
  int m_id    = 0;
  int m_sel   = 0;

  always @(negedge CLK) begin
    int   w;
    int   a, b, op;
    exp_t e;
    if (!RST_N) begin
      chk("gnt_in_reset", int'(bus.GNT0) | int'(bus.GNT1), 0);
      m_cnt  = 0;
      m_last = 1;
      m_sel  = 0;
      sbq.delete();
    end else begin
      chk("busy", int'(bus.BUSY), (m_cnt != 0) ? 1 : 0);
      chk("sel", int'(bus.SEL), m_sel);
      chk("done0_timing", int'(bus.DONE0), (m_cnt == 1 && m_id == 0) ? 1 : 0);
      chk("done1_timing", int'(bus.DONE1), (m_cnt == 1 && m_id == 1) ? 1 : 0);
      if (m_cnt == 0) begin
        w = -1;
        if (bus.REQ0 && bus.REQ1) w = (m_last == 0) ? 1 : 0;
        else if (bus.REQ0)        w = 0;
        else if (bus.REQ1)        w = 1;
        chk("gnt0", int'(bus.GNT0), (w == 0) ? 1 : 0);
        chk("gnt1", int'(bus.GNT1), (w == 1) ? 1 : 0);
        if (w >= 0) begin
          a  = (w == 0) ? int'(bus.A0)  : int'(bus.A1);
          b  = (w == 0) ? int'(bus.B0)  : int'(bus.B1);
          op = (w == 0) ? int'(bus.OP0) : int'(bus.OP1);
          e.id = w;
          if (op == 0) begin
            e.res  = (a + b) & MASK;
            e.cout = (a + b > MASK) ? 1 : 0;
          end else begin
            e.res  = (a - b) & MASK;
            e.cout = (a < b) ? 1 : 0;
          end
          sbq.push_back(e);
          m_last = w;
          m_id   = w;
          m_sel  = op;
          m_cnt  = 2;
        end
      end else begin
        chk("gnt_while_busy", int'(bus.GNT0) | int'(bus.GNT1), 0);
        m_cnt--;
      end
    end
  end

  // Monitor: pops an expectation whenever a DONE pulse appears and checks
  // that RES/COUT hold between results.
  int mon_res  = 0;
  int mon_cout = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      mon_res  = 0;
      mon_cout = 0;
    end else if (bus.DONE0 || bus.DONE1) begin
      chk("done_exclusive", int'(bus.DONE0) & int'(bus.DONE1), 0);
      if (sbq.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        pops++;
        chk("done_id", bus.DONE1 ? 1 : 0, e.id);
        chk("res", int'(bus.RES), e.res);
        chk("cout", int'(bus.COUT), e.cout);
        mon_res  = e.res;
        mon_cout = e.cout;
      end
    end else begin
      chk("res_hold", int'(bus.RES), mon_res);
      chk("cout_hold", int'(bus.COUT), mon_cout);
    end
  end

  function automatic int pick();
    int corner [5] = '{0, 1, 255, 128, 127};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return int'($urandom_range(0, MASK));
  endfunction

  // Stimulus: requesters hold REQ until granted, occasionally withdraw, and
  // occasionally keep REQ high after a grant as a fresh request.
  initial begin
    int req [2];
    int g   [2];
    int mode;
    req = '{0, 0};
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    bus.OP0  = 1'b0; bus.OP1  = 1'b0;
    bus.A0   = '0;   bus.B0   = '0;
    bus.A1   = '0;   bus.B1   = '0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge CLK);
      g[0] = int'(bus.GNT0);
      g[1] = int'(bus.GNT1);
      @(posedge CLK);
      #1;
      // 0: random traffic, 1: both requesters held high, 2: random with resets
      mode = (cyc < 600) ? 0 : (cyc < 640) ? 1 : 2;
      if (cyc == 598 || cyc == 599) RST_N = 1'b0;
      else if (mode == 2)           RST_N = ($urandom_range(0, 49) != 0);
      else                          RST_N = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (mode == 1)      req[i] = 1;
        else if (g[i] != 0) req[i] = ($urandom_range(0, 99) < 30) ? 1 : 0;
        else if (req[i] != 0) req[i] = ($urandom_range(0, 99) >= 5) ? 1 : 0;
        else                req[i] = ($urandom_range(0, 99) < 50) ? 1 : 0;
      end
      bus.REQ0 = req[0][0];
      bus.REQ1 = req[1][0];
      bus.OP0  = $urandom_range(0, 1) == 1;
      bus.OP1  = $urandom_range(0, 1) == 1;
      bus.A0   = W'(pick());
      bus.B0   = W'(pick());
      bus.A1   = W'(pick());
      bus.B1   = W'(pick());
    end

    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    RST_N    = 1'b1;
    repeat (6) @(negedge CLK);
    chk("enough_operations", (pops > 100) ? 1 : 0, 1);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_sumrest_arbiter.md
MOD_SUMREST_ARBITER -- requirements
Module: mod_sumrest_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have ports REQ0/REQ1, input, 1 bit each: operation request from requester 0/1.
REQ-005 The block SHALL have ports OP0/OP1, input, 1 bit each: 0 = sum (A+B), 1 = rest (A-B).
REQ-006 The block SHALL have ports A0/B0 and A1/B1, input, W bits each: operands of requester 0/1.
REQ-007 The block SHALL have ports GNT0/GNT1, output, 1 bit each: one-cycle accept pulse to requester 0/1.
REQ-008 The block SHALL have port SEL, output, 1 bit: registered select to the sum/rest 2:1 mux (0 sum, 1 rest).
REQ-009 The block SHALL have port RES, output, W bits: registered result.
REQ-010 The block SHALL have port COUT, output, 1 bit: carry-out for sum, borrow for rest.
REQ-011 The block SHALL have ports DONE0/DONE1, output, 1 bit each: one-cycle result-valid pulse to requester 0/1.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, DONE; IDLE->EXEC on a grant, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-014 In IDLE with any REQ high, the block SHALL assert exactly one GNT combinationally in that cycle and latch that requester's A, B and OP plus a winner ID at the clock edge.
REQ-015 Arbitration SHALL be round-robin: a last-served pointer updates on each grant; when both REQ are high, the requester not last served wins.
REQ-016 With a single REQ high, that requester SHALL win regardless of the pointer.
REQ-017 REQ inputs SHALL be ignored in EXEC and DONE; GNT SHALL be 0 outside IDLE; a requester holds REQ until it sees GNT.
REQ-018 SEL SHALL equal the latched OP from the EXEC cycle onward and hold until the next grant.
REQ-019 In EXEC, the block SHALL compute the sum as {COUT,RES} = A+B (W+1 bits) and the rest as RES = (A-B) mod 2^W, with COUT = 1 iff A<B (unsigned).
REQ-020 RES and COUT SHALL register at the EXEC->DONE edge and hold until the next such edge.
REQ-021 In DONE, the block SHALL pulse DONE of the latched winner for exactly one cycle and keep the other DONE low.
REQ-022 Latency SHALL be fixed: GNT in cycle n, DONE in cycle n+2, next GNT possible in cycle n+3; sustained throughput is one operation per 3 cycles.
REQ-023 A REQ deasserted before its GNT SHALL cause no operation; REQ held after GNT SHALL be treated as a new request at the next IDLE.

Reset
REQ-024 While RST_N = 0 at a clock edge, the FSM SHALL go to IDLE, the pointer SHALL be set so requester 0 wins the first tie, and SEL, RES, COUT, DONE0, DONE1 and BUSY SHALL be 0.
REQ-025 A reset asserted in EXEC or DONE SHALL abort the operation with no DONE pulse; GNT SHALL be 0 while RST_N = 0.

Verification (W=8)
REQ-026 After reset, REQ0=1, OP0=0, A0=8'h0F, B0=8'h01 -> GNT0 in cycle 0, SEL=0, then RES=8'h10, COUT=0, DONE0 pulse in cycle 2, BUSY high cycles 1-2.
REQ-027 REQ1 only, OP1=1, A1=8'h03, B1=8'h05 -> GNT1, SEL=1, RES=8'hFE, COUT=1, DONE1 only.
REQ-028 Sum overflow: A=8'hFF, B=8'h01, OP=0 -> RES=8'h00, COUT=1.
REQ-029 REQ0 and REQ1 held high continuously from reset -> grants alternate 0,1,0,1 at cycles 0,3,6,9; DONE pulses match the winners at cycles 2,5,8,11.
REQ-030 RST_N low during EXEC -> next cycle IDLE, BUSY=0, RES=0, no DONE pulse; first request after release granted normally.
REQ-031 REQ1 raised during EXEC of a requester-0 operation and changing OP1/A1/B1 -> in-flight RES unaffected; REQ1 granted at the next IDLE with its values sampled there.
